// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Two-master arbiter in front of the SDRAM controller's single 16-bit port.
// It sits between the video fetch path and the CPU memory controller on one
// side and sdram_pnru on the other, all in the clk_sys domain.
//
// Only one transaction is in flight at a time, and the FSM walks
// IDLE -> ISSUE -> WAIT -> IDLE. Video has fixed priority. When the optional
// starvation guard is compiled in, the CPU also wins once VID_MAX_RUN video
// grants have gone by in a row while it was waiting.
//
// Build option:
//   SDRAM_ARB_STARVE_GUARD_EN  defined     -> run_cnt / VID_MAX_RUN guard active
//                              not defined -> strict video priority
//
// Parameters:
//   ADDR_W       SDRAM word address width (16-bit words)
//   VID_MAX_RUN  max consecutive video grants while the CPU waits (1..15)
//
// Ports:
//   clk_i, rst_i                   system clock, async active-high reset
//   vid_req_i / vid_addr_i         video read request (held until gnt) + address
//   vid_gnt_o                      1-cycle pulse: video command latched
//   vid_ack_o / vid_rdata_o        1-cycle pulse with read data valid
//   cpu_req_i / cpu_we_i           CPU request (held until gnt), 1 = write
//   cpu_addr_i / cpu_wdata_i       CPU address and write data
//   cpu_wmask_i                    CPU byte enables
//   cpu_gnt_o                      1-cycle pulse: CPU command latched
//   cpu_ack_o / cpu_rdata_o        1-cycle pulse: read data valid or write done
//   sdram_rd_o / sdram_wr_o        command strobes to the controller
//   sdram_addr_o / sdram_wdata_o   latched command payload
//   sdram_wmask_o                  latched byte mask
//   sdram_rdy_i                    controller accepts the strobe this cycle
//   sdram_ack_i / sdram_rdata_i    controller completion, read data valid
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int VID_MAX_RUN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_gnt_o,
    output logic              vid_ack_o,
    output logic [15:0]       vid_rdata_o,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    input  logic [1:0]        cpu_wmask_i,
    output logic              cpu_gnt_o,
    output logic              cpu_ack_o,
    output logic [15:0]       cpu_rdata_o,

    output logic              sdram_rd_o,
    output logic              sdram_wr_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic [15:0]       sdram_wdata_o,
    output logic [1:0]        sdram_wmask_o,
    input  logic              sdram_rdy_i,
    input  logic              sdram_ack_i,
    input  logic [15:0]       sdram_rdata_i
);

    // Reject an out-of-range run limit at elaboration. run_cnt is only 4 bits wide.
    if (VID_MAX_RUN < 1 || VID_MAX_RUN > 15) begin : g_bad_vid_max_run
        $error("sdram_arbiter: VID_MAX_RUN must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;
    logic   owner_cpu;   // owner of the transaction in flight
    logic   cpu_wins;    // arbitration result, only meaningful in IDLE

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] MAX_RUN = 4'(VID_MAX_RUN);

    // Video grants in a row that were given while the CPU was waiting.
    logic [3:0] run_cnt;

    assign cpu_wins = cpu_req_i && (!vid_req_i || run_cnt == MAX_RUN);
`else
    assign cpu_wins = cpu_req_i && !vid_req_i;
`endif

    // NOTE: every register here is updated with non-blocking assignments, so
    // all decisions in a cycle see the pre-edge values. The registered
    // gnt/ack/strobe outputs then change together on the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            owner_cpu     <= 1'b0;
            vid_gnt_o     <= 1'b0;
            cpu_gnt_o     <= 1'b0;
            vid_ack_o     <= 1'b0;
            cpu_ack_o     <= 1'b0;
            vid_rdata_o   <= '0;
            cpu_rdata_o   <= '0;
            sdram_rd_o    <= 1'b0;
            sdram_wr_o    <= 1'b0;
            sdram_addr_o  <= '0;
            sdram_wdata_o <= '0;
            sdram_wmask_o <= '0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
            run_cnt       <= '0;
`endif
        end else begin
            // gnt and ack are single-cycle pulses. Each is raised only in the
            // branch below that needs it.
            vid_gnt_o <= 1'b0;
            cpu_gnt_o <= 1'b0;
            vid_ack_o <= 1'b0;
            cpu_ack_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (vid_req_i || cpu_req_i) begin
                        state     <= S_ISSUE;
                        owner_cpu <= cpu_wins;
                        if (cpu_wins) begin
                            cpu_gnt_o     <= 1'b1;
                            sdram_addr_o  <= cpu_addr_i;
                            sdram_wdata_o <= cpu_wdata_i;
                            sdram_wmask_o <= cpu_wmask_i;
                            sdram_rd_o    <= !cpu_we_i;
                            sdram_wr_o    <= cpu_we_i;
                        end else begin
                            // Video only reads, so it has no data or mask to carry.
                            vid_gnt_o     <= 1'b1;
                            sdram_addr_o  <= vid_addr_i;
                            sdram_wdata_o <= '0;
                            sdram_wmask_o <= '0;
                            sdram_rd_o    <= 1'b1;
                            sdram_wr_o    <= 1'b0;
                        end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
                        // Count only the video wins that made a waiting CPU wait.
                        // Any CPU grant, or a video grant with no CPU waiting,
                        // starts a fresh run.
                        if (cpu_wins || !cpu_req_i) begin
                            run_cnt <= '0;
                        end else if (run_cnt != MAX_RUN) begin
                            run_cnt <= run_cnt + 4'd1;
                        end
`endif
                    end
                end

                S_ISSUE: begin
                    // The strobe stays up with a stable payload until the
                    // controller takes it. The ready cycle is the transfer.
                    if (sdram_rdy_i) begin
                        sdram_rd_o <= 1'b0;
                        sdram_wr_o <= 1'b0;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Only the owner's read data register changes. The other
                    // master keeps its last value.
                    if (sdram_ack_i) begin
                        if (owner_cpu) begin
                            cpu_rdata_o <= sdram_rdata_i;
                            cpu_ack_o   <= 1'b1;
                        end else begin
                            vid_rdata_o <= sdram_rdata_i;
                            vid_ack_o   <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: begin
                    sdram_rd_o <= 1'b0;
                    sdram_wr_o <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
